// File: rtl/cdb_broadcast.sv
// rtl/cdb_broadcast.sv - Common Data Bus broadcaster: per-FU result buffers, round-robin pick of up to CDB_W per cycle
// Each cdb_packet slot is packed as {tag, value, valid} with valid in bit 0.
module cdb_broadcast #(
  parameter  int NUM_FU = 5,
  parameter  int CDB_W  = 3,
  parameter  int ROBLEN = 32,
  parameter  int XLEN   = 32,
  localparam int TAG_W  = $clog2(ROBLEN),
  localparam int PKT_W  = TAG_W + XLEN + 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              squash,
  input  logic [NUM_FU-1:0]                 fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]      fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]       fu_value,
  output logic [NUM_FU-1:0]                 fu_ready,
  output logic [CDB_W-1:0][PKT_W-1:0]       cdb_packet
);

  localparam int PTR_W = $clog2(NUM_FU);
  localparam int CNT_W = $clog2(CDB_W + 1);

  logic [NUM_FU-1:0]             r_full;
  logic [NUM_FU-1:0][TAG_W-1:0]  r_tag;
  logic [NUM_FU-1:0][XLEN-1:0]   r_value;
  logic [PTR_W-1:0]              r_ptr;
  logic [CDB_W-1:0][PKT_W-1:0]   r_pkt;

  logic [NUM_FU-1:0]             w_grant;
  logic [NUM_FU-1:0]             w_accept;
  logic [CDB_W-1:0][PTR_W-1:0]   w_sel;
  logic [CDB_W-1:0]              w_slot_vld;
  logic [PTR_W-1:0]              w_next_ptr;
  logic [PTR_W:0]                w_idx;
  logic [CNT_W-1:0]              w_cnt;

  // Scan from the round-robin pointer; the k-th full buffer found feeds slot k.
  always_comb begin
    w_grant    = '0;
    w_sel      = '0;
    w_slot_vld = '0;
    w_next_ptr = r_ptr;
    w_cnt      = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NUM_FU)) w_idx = w_idx - (PTR_W+1)'(NUM_FU);
      if (r_full[w_idx[PTR_W-1:0]] && (w_cnt < CNT_W'(CDB_W))) begin
        w_grant[w_idx[PTR_W-1:0]] = 1'b1;
        for (int s = 0; s < CDB_W; s++) begin
          if (w_cnt == CNT_W'(s)) begin
            w_sel[s]      = w_idx[PTR_W-1:0];
            w_slot_vld[s] = 1'b1;
          end
        end
        w_next_ptr = (w_idx[PTR_W-1:0] == PTR_W'(NUM_FU - 1)) ? '0 : w_idx[PTR_W-1:0] + PTR_W'(1);
        w_cnt      = w_cnt + CNT_W'(1);
      end
    end
  end

  assign fu_ready   = {NUM_FU{reset}} & (~r_full | w_grant);
  assign w_accept   = fu_valid & fu_ready & {NUM_FU{~squash}};
  assign cdb_packet = r_pkt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_full  <= '0;
      r_tag   <= '0;
      r_value <= '0;
      r_ptr   <= '0;
      r_pkt   <= '0;
    end else if (squash) begin
      r_full <= '0;
      r_ptr  <= '0;
      r_pkt  <= '0;
    end else begin
      for (int s = 0; s < CDB_W; s++) begin
        r_pkt[s] <= w_slot_vld[s] ? {r_tag[w_sel[s]], r_value[w_sel[s]], 1'b1} : '0;
      end
      // A refill at the same edge as a grant keeps the buffer full with the new result.
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_accept[i]) begin
          r_full[i]  <= 1'b1;
          r_tag[i]   <= fu_tag[i];
          r_value[i] <= fu_value[i];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
      if (|w_grant) r_ptr <= w_next_ptr;
    end
  end

endmodule
